// File: rtl/bram_mat_seq.sv
// bram_mat_seq: owns the single-port matrix BRAM and runs one weight-stationary
// systolic array pass per start: weight load, staggered input stream, buffered result write-back.
module bram_mat_seq #(
   parameter int unsigned ROWS       = 4,
   parameter int unsigned COLS       = 4,
   parameter int unsigned WORD_SIZE  = 16,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned W_BASE     = 0,
   parameter int unsigned IN_BASE    = 4,
   parameter int unsigned OUT_BASE   = 11,
   parameter int unsigned DRAIN_MAX  = 64,
   localparam int unsigned MEM_PORT_WIDTH = COLS * WORD_SIZE,
   localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      error,
   output logic                      mem_we,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [MEM_PORT_WIDTH-1:0] mem_di,
   input  logic [MEM_PORT_WIDTH-1:0] mem_dout,
   output logic                      sa_w_load,
   output logic [ROW_W-1:0]          sa_w_row,
   output logic [MEM_PORT_WIDTH-1:0] sa_w_data,
   output logic                      sa_in_valid,
   output logic [MEM_PORT_WIDTH-1:0] sa_in_data,
   input  logic                      sa_out_valid,
   input  logic [MEM_PORT_WIDTH-1:0] sa_out_data
);

   localparam int unsigned CW   = $clog2(ROWS + COLS);
   localparam int unsigned PW   = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned CNTW = $clog2(COLS + 1);
   localparam int unsigned DW   = $clog2(DRAIN_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_WRITE, S_DONE
   } state_t;

   state_t              state, state_n;
   logic [CW-1:0]       rd_cnt, rd_cnt_n, rd_nxt;
   logic [DW-1:0]       drain_cnt, drain_cnt_n;
   logic [PW-1:0]       wr_cnt, wr_cnt_n, wr_nxt;
   logic                error_n, done_n, busy_n, mem_we_n, sa_w_load_n, sa_in_valid_n;
   logic [ADDR_WIDTH-1:0]     mem_addr_n;
   logic [MEM_PORT_WIDTH-1:0] mem_di_n;
   logic [ROW_W-1:0]          sa_w_row_n;

   // Result buffer: circular FIFO so capture never needs the BRAM port.
   logic [MEM_PORT_WIDTH-1:0] buffer [COLS];
   logic [PW-1:0]       wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
   logic [CNTW-1:0]     count, count_n;
   logic                capture, push, pop, overflow, clear;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(COLS - 1)) ? '0 : p + PW'(1);
   endfunction

   // Array data ports are direct copies of the BRAM read port.
   assign sa_w_data  = mem_dout;
   assign sa_in_data = mem_dout;

   always_comb begin
      state_n       = state;
      rd_cnt_n      = rd_cnt;
      drain_cnt_n   = drain_cnt;
      wr_cnt_n      = wr_cnt;
      error_n       = error;
      done_n        = 1'b0;
      mem_we_n      = 1'b0;
      mem_addr_n    = '0;
      mem_di_n      = '0;
      sa_w_load_n   = 1'b0;
      sa_w_row_n    = '0;
      sa_in_valid_n = 1'b0;
      clear         = 1'b0;
      pop           = 1'b0;
      capture       = 1'b0;
      rd_nxt        = rd_cnt + CW'(1);
      wr_nxt        = wr_cnt + PW'(1);

      case (state)
         S_IDLE: begin
            if (start) begin
               state_n     = S_LOAD_W;
               clear       = 1'b1;
               error_n     = 1'b0;
               rd_cnt_n    = '0;
               drain_cnt_n = '0;
               wr_cnt_n    = '0;
               mem_addr_n  = ADDR_WIDTH'(W_BASE);
            end
         end
         S_LOAD_W: begin
            capture     = 1'b1;
            sa_w_load_n = 1'b1;
            sa_w_row_n  = ROW_W'(rd_cnt);
            if (rd_cnt == CW'(ROWS - 1)) begin
               state_n    = S_STREAM;
               rd_cnt_n   = '0;
               mem_addr_n = ADDR_WIDTH'(IN_BASE);
            end else begin
               rd_cnt_n   = rd_nxt;
               mem_addr_n = ADDR_WIDTH'(W_BASE) + ADDR_WIDTH'(rd_nxt);
            end
         end
         S_STREAM: begin
            capture       = 1'b1;
            sa_in_valid_n = 1'b1;
            if (rd_cnt == CW'(ROWS + COLS - 2)) begin
               state_n     = S_DRAIN;
               drain_cnt_n = '0;
            end else begin
               rd_cnt_n   = rd_nxt;
               mem_addr_n = ADDR_WIDTH'(IN_BASE) + ADDR_WIDTH'(rd_nxt);
            end
         end
         S_DRAIN: begin
            capture = 1'b1;
            if (count == CNTW'(COLS)) begin
               state_n    = S_WRITE;
               wr_cnt_n   = '0;
               pop        = 1'b1;
               mem_we_n   = 1'b1;
               mem_addr_n = ADDR_WIDTH'(OUT_BASE);
               mem_di_n   = buffer[rd_ptr];
            end else if (drain_cnt == DW'(DRAIN_MAX - 1)) begin
               state_n = S_DONE;
               error_n = 1'b1;
            end else begin
               drain_cnt_n = drain_cnt + DW'(1);
            end
         end
         S_WRITE: begin
            capture = 1'b1;
            if (wr_cnt == PW'(COLS - 1)) begin
               state_n = S_DONE;
            end else begin
               wr_cnt_n   = wr_nxt;
               pop        = 1'b1;
               mem_we_n   = 1'b1;
               mem_addr_n = ADDR_WIDTH'(OUT_BASE) + ADDR_WIDTH'(wr_nxt);
               mem_di_n   = buffer[rd_ptr];
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase

      // A result arriving while the buffer is full is dropped and flagged.
      push     = capture && sa_out_valid && (count != CNTW'(COLS));
      overflow = capture && sa_out_valid && (count == CNTW'(COLS));
      if (overflow) error_n = 1'b1;
      if (state == S_WRITE && state_n == S_DONE) done_n = ~error_n;
      busy_n = (state_n != S_IDLE);

      wr_ptr_n = wr_ptr;
      rd_ptr_n = rd_ptr;
      count_n  = count;
      if (clear) begin
         wr_ptr_n = '0;
         rd_ptr_n = '0;
         count_n  = '0;
      end else begin
         if (push) wr_ptr_n = ptr_inc(wr_ptr);
         if (pop)  rd_ptr_n = ptr_inc(rd_ptr);
         if (push && !pop)      count_n = count + CNTW'(1);
         else if (pop && !push) count_n = count - CNTW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         rd_cnt      <= '0;
         drain_cnt   <= '0;
         wr_cnt      <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_di      <= '0;
         sa_w_load   <= 1'b0;
         sa_w_row    <= '0;
         sa_in_valid <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         for (int i = 0; i < int'(COLS); i++) buffer[PW'(i)] <= '0;
      end else begin
         state       <= state_n;
         rd_cnt      <= rd_cnt_n;
         drain_cnt   <= drain_cnt_n;
         wr_cnt      <= wr_cnt_n;
         busy        <= busy_n;
         done        <= done_n;
         error       <= error_n;
         mem_we      <= mem_we_n;
         mem_addr    <= mem_addr_n;
         mem_di      <= mem_di_n;
         sa_w_load   <= sa_w_load_n;
         sa_w_row    <= sa_w_row_n;
         sa_in_valid <= sa_in_valid_n;
         wr_ptr      <= wr_ptr_n;
         rd_ptr      <= rd_ptr_n;
         count       <= count_n;
         if (push) buffer[wr_ptr] <= sa_out_data;
      end
   end

endmodule

// File: tb/tb_bram_mat_seq.sv
// Directed bench for bram_mat_seq: BRAM model, scripted array responses and
// hand-computed expectations for normal, early, timeout, overflow, reset and start-handling runs.
module tb_bram_mat_seq;

   localparam int unsigned MPW = 64;

   logic           clk = 1'b0;
   logic           rst, start, busy, done, error, mem_we;
   logic [31:0]    mem_addr;
   logic [MPW-1:0] mem_di, mem_dout, sa_w_data, sa_in_data, sa_out_data;
   logic           sa_w_load, sa_in_valid, sa_out_valid;
   logic [1:0]     sa_w_row;

   always #5 clk = ~clk;

   bram_mat_seq dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di), .mem_dout(mem_dout),
      .sa_w_load(sa_w_load), .sa_w_row(sa_w_row), .sa_w_data(sa_w_data),
      .sa_in_valid(sa_in_valid), .sa_in_data(sa_in_data),
      .sa_out_valid(sa_out_valid), .sa_out_data(sa_out_data)
   );

   // Registered-read BRAM with a host port for preloading while the DUT is idle.
   logic [MPW-1:0] bram [32];
   logic           host_we;
   logic [4:0]     host_addr;
   logic [MPW-1:0] host_data;
   always @(posedge clk) begin
      if (host_we) bram[host_addr] <= host_data;
      else if (mem_we) bram[mem_addr[4:0]] <= mem_di;
      mem_dout <= bram[mem_addr[4:0]];
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // A (inputs, row-major) times W (weights); product rows hand-computed.
   int a_m [4][4] = '{'{1,2,0,1}, '{0,1,3,0}, '{2,0,1,1}, '{1,1,1,1}};
   logic [MPW-1:0] w_line [4] = '{64'h0000_0002_0000_0001, 64'h0003_0000_0001_0000,
                                  64'h0000_0000_0001_0001, 64'h0001_0001_0000_0002};
   logic [MPW-1:0] prod   [4] = '{64'h0007_0003_0002_0003, 64'h0003_0000_0004_0003,
                                  64'h0001_0005_0001_0005, 64'h0004_0003_0002_0004};
   logic [MPW-1:0] in_line [7];

   logic [127:0]   sched;
   logic [MPW-1:0] resp [8];

   int             wl_cyc[$], wl_row[$], in_cyc[$], we_cyc[$], done_cyc[$];
   logic [MPW-1:0] wl_data[$], in_data[$], we_data[$];
   logic [31:0]    we_addr[$];
   logic           busy_log [128];
   int             idle_at;

   task automatic poke(input int a, input logic [MPW-1:0] d);
      @(posedge clk); #1;
      host_we = 1'b1; host_addr = 5'(a); host_data = d;
      @(posedge clk); #1;
      host_we = 1'b0;
   endtask

   task automatic clear_out();
      for (int k = 11; k < 16; k++) poke(k, '0);
   endtask

   // Runs one sequence from a start at cycle 0, logging every strobe by cycle number.
   task automatic do_run(input int mode, input int max_cyc, input bit stop_on_idle);
      int ri;
      wl_cyc.delete(); wl_row.delete(); wl_data.delete(); in_cyc.delete(); in_data.delete();
      we_cyc.delete(); we_addr.delete(); we_data.delete(); done_cyc.delete();
      for (int i = 0; i < 128; i++) busy_log[i] = 1'b1;
      idle_at = -1;
      ri = 0;
      @(posedge clk); #1;
      for (int c = 0; c < max_cyc; c++) begin
         case (mode)
            1:       start = (c <= 18);
            2:       start = (c == 0 || c == 14);
            default: start = (c == 0);
         endcase
         sa_out_valid = 1'b0;
         sa_out_data  = '0;
         if (c < 128 && sched[c] && ri < 8) begin
            sa_out_valid = 1'b1;
            sa_out_data  = resp[ri];
            ri++;
         end
         @(negedge clk);
         if (c < 128) busy_log[c] = busy;
         if (sa_w_load) begin
            wl_cyc.push_back(c); wl_row.push_back(int'(sa_w_row)); wl_data.push_back(sa_w_data);
         end
         if (sa_in_valid) begin in_cyc.push_back(c); in_data.push_back(sa_in_data); end
         if (mem_we) begin we_cyc.push_back(c); we_addr.push_back(mem_addr); we_data.push_back(mem_di); end
         if (done) done_cyc.push_back(c);
         if (c > 0 && !busy && idle_at < 0) idle_at = c;
         if (stop_on_idle && idle_at >= 0) break;
         @(posedge clk); #1;
      end
      start = 1'b0;
      sa_out_valid = 1'b0;
      sa_out_data = '0;
   endtask

   task automatic check_writes(input string p, input int first_done);
      check({p, "_n_we"}, 64'(we_cyc.size()), 64'd4);
      for (int k = 0; k < 4 && k < we_cyc.size(); k++) begin
         check($sformatf("%s_we_cyc%0d", p, k), 64'(we_cyc[k]), 64'(13 + k));
         check($sformatf("%s_we_addr%0d", p, k), 64'(we_addr[k]), 64'(11 + k));
         check($sformatf("%s_we_data%0d", p, k), we_data[k], resp[k]);
         check($sformatf("%s_line%0d", p, 11 + k), bram[11 + k], resp[k]);
      end
      check({p, "_n_done"}, 64'(done_cyc.size()), 64'd1);
      if (done_cyc.size() > 0) check({p, "_done_cyc"}, 64'(done_cyc[0]), 64'(first_done));
      check({p, "_error"}, 64'(error), 64'd0);
      check({p, "_idle_at"}, 64'(idle_at), 64'd18);
   endtask

   task automatic check_reads(input string p);
      check({p, "_n_wl"}, 64'(wl_cyc.size()), 64'd4);
      for (int i = 0; i < 4 && i < wl_cyc.size(); i++) begin
         check($sformatf("%s_wl_cyc%0d", p, i), 64'(wl_cyc[i]), 64'(2 + i));
         check($sformatf("%s_wl_row%0d", p, i), 64'(wl_row[i]), 64'(i));
         check($sformatf("%s_wl_data%0d", p, i), wl_data[i], w_line[i]);
      end
      check({p, "_n_in"}, 64'(in_cyc.size()), 64'd7);
      for (int t = 0; t < 7 && t < in_cyc.size(); t++) begin
         check($sformatf("%s_in_cyc%0d", p, t), 64'(in_cyc[t]), 64'(6 + t));
         check($sformatf("%s_in_data%0d", p, t), in_data[t], in_line[t]);
      end
   endtask

   initial begin
      logic [MPW-1:0] ln, w, x;
      int sum;
      rst = 1'b1; start = 1'b0; sa_out_valid = 1'b0; sa_out_data = '0;
      host_we = 1'b0; host_addr = '0; host_data = '0;
      sched = '0;
      for (int i = 0; i < 8; i++) resp[i] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      check("rst_mem_we", 64'(mem_we), 64'd0);
      check("rst_w_load", 64'(sa_w_load), 64'd0);
      check("rst_in_valid", 64'(sa_in_valid), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_mem_di", mem_di, 64'd0);
      check("rst_w_row", 64'(sa_w_row), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int t = 0; t < 7; t++) begin
         ln = '0;
         for (int r = 0; r < 4; r++)
            if (t - r >= 0 && t - r < 4) ln[16*r +: 16] = 16'(a_m[t-r][r]);
         in_line[t] = ln;
      end
      for (int k = 0; k < 32; k++) begin
         if (k < 4)       poke(k, w_line[k]);
         else if (k < 11) poke(k, in_line[k-4]);
         else             poke(k, '0);
      end

      // Normal run: product rows returned during STREAM.
      sched = '0; sched[10:7] = 4'hF;
      for (int k = 0; k < 4; k++) resp[k] = prod[k];
      do_run(0, 60, 1'b1);
      check_reads("run1");
      check_writes("run1", 17);
      // Product of the captured weight and de-staggered input lines.
      if (wl_data.size() == 4 && in_data.size() == 7) begin
         for (int c = 0; c < 4; c++) begin
            ln = '0;
            for (int j = 0; j < 4; j++) begin
               sum = 0;
               for (int i = 0; i < 4; i++) begin
                  w = wl_data[i];
                  x = in_data[c+i];
                  sum += int'(w[16*j +: 16]) * int'(x[16*i +: 16]);
               end
               ln[16*j +: 16] = 16'(sum);
            end
            check($sformatf("run1_model_row%0d", c), ln, prod[c]);
         end
      end

      // Early results interleaved with LOAD_W/STREAM.
      clear_out();
      sched = '0; sched[3] = 1'b1; sched[6] = 1'b1; sched[9] = 1'b1; sched[11] = 1'b1;
      for (int k = 0; k < 4; k++) resp[k] = 64'hA000_0000_0000_0000 | 64'(k + 1);
      do_run(0, 60, 1'b1);
      check_writes("early", 17);

      // Only three results: drain timeout.
      clear_out();
      sched = '0; sched[9:7] = 3'h7;
      for (int k = 0; k < 4; k++) resp[k] = prod[k];
      do_run(0, 120, 1'b1);
      check("tmo_n_we", 64'(we_cyc.size()), 64'd0);
      check("tmo_n_done", 64'(done_cyc.size()), 64'd0);
      check("tmo_error", 64'(error), 64'd1);
      check("tmo_idle_at", 64'(idle_at), 64'd77);
      check("tmo_line11", bram[11], 64'd0);

      // Five results: fifth dropped, error set, no done.
      clear_out();
      sched = '0; sched[10:6] = 5'h1F;
      for (int k = 0; k < 5; k++) resp[k] = 64'hB000_0000_0000_0000 | 64'(k + 1);
      do_run(0, 60, 1'b1);
      check("ovf_n_we", 64'(we_cyc.size()), 64'd4);
      for (int k = 0; k < 4; k++) check($sformatf("ovf_line%0d", 11 + k), bram[11 + k], resp[k]);
      check("ovf_line15", bram[15], 64'd0);
      check("ovf_n_done", 64'(done_cyc.size()), 64'd0);
      check("ovf_error", 64'(error), 64'd1);
      check("ovf_idle_at", 64'(idle_at), 64'd18);

      // Reset mid-STREAM; the accepted start first clears the sticky error.
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("rs_err_cleared", 64'(error), 64'd0);
      check("rs_busy_c1", 64'(busy), 64'd1);
      repeat (6) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rs_in_valid_c7", 64'(sa_in_valid), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rs_busy", 64'(busy), 64'd0);
      check("rs_in_valid", 64'(sa_in_valid), 64'd0);
      check("rs_w_load", 64'(sa_w_load), 64'd0);
      check("rs_mem_addr", 64'(mem_addr), 64'd0);
      check("rs_mem_we", 64'(mem_we), 64'd0);
      check("rs_error", 64'(error), 64'd0);
      @(negedge clk);
      check("rs_in_valid_c9", 64'(sa_in_valid), 64'd0);
      check("rs_busy_c9", 64'(busy), 64'd0);
      clear_out();
      sched = '0; sched[10:7] = 4'hF;
      for (int k = 0; k < 4; k++) resp[k] = prod[k];
      do_run(0, 60, 1'b1);
      check_writes("post_rst", 17);

      // Start held high: second run begins the cycle after IDLE re-entry.
      sched = '0; sched[10:7] = 4'hF; sched[28:25] = 4'hF;
      for (int k = 0; k < 8; k++) resp[k] = prod[k % 4];
      do_run(1, 40, 1'b0);
      check("hold_idle_at", 64'(idle_at), 64'd18);
      check("hold_busy_c19", 64'(busy_log[19]), 64'd1);
      check("hold_n_done", 64'(done_cyc.size()), 64'd2);
      if (done_cyc.size() == 2) begin
         check("hold_done0", 64'(done_cyc[0]), 64'd17);
         check("hold_done1", 64'(done_cyc[1]), 64'd35);
      end
      check("hold_n_wl", 64'(wl_cyc.size()), 64'd8);
      if (wl_cyc.size() > 4) check("hold_wl4_cyc", 64'(wl_cyc[4]), 64'd20);
      check("hold_busy_c36", 64'(busy_log[36]), 64'd0);

      // Start pulsed during WRITE is ignored.
      sched = '0; sched[10:7] = 4'hF;
      for (int k = 0; k < 4; k++) resp[k] = prod[k];
      do_run(2, 30, 1'b0);
      check("pulse_n_done", 64'(done_cyc.size()), 64'd1);
      if (done_cyc.size() > 0) check("pulse_done_cyc", 64'(done_cyc[0]), 64'd17);
      check("pulse_n_wl", 64'(wl_cyc.size()), 64'd4);
      check("pulse_n_we", 64'(we_cyc.size()), 64'd4);
      check("pulse_busy_c18", 64'(busy_log[18]), 64'd0);
      check("pulse_busy_c19", 64'(busy_log[19]), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bram_mat_seq.md
# bram_mat_seq

Sequencer that owns the single-port matrix BRAM (`bram_mat`) and drives a weight-stationary systolic array from it. On `start` it reads the ROWS weight lines into the array, streams the ROWS+COLS-1 staggered input lines, captures the COLS result rows the array returns into an internal buffer, then writes them back to the output region of the same BRAM. The buffer keeps result capture and BRAM reads from ever competing for the one port.

## Interface
- ROWS, 4, systolic array rows; also the number of weight lines.
- COLS, 4, systolic array columns; also the number of result rows.
- WORD_SIZE, 16, element width; port width `MEM_PORT_WIDTH` = COLS*WORD_SIZE.
- ADDR_WIDTH, 32, BRAM address width.
- W_BASE, 0, first weight line address.
- IN_BASE, 4, first staggered input line address.
- OUT_BASE, 11, first result line address.
- DRAIN_MAX, 64, cycles allowed after the last input before the run times out.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level sampled in IDLE only; starts one run.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a run completes normally.
- error  out  1  sticky; set on timeout or buffer overflow; cleared by rst or by the next accepted start.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  ADDR_WIDTH  BRAM address.
- mem_di  out  `MEM_PORT_WIDTH`  BRAM write data.
- mem_dout  in  `MEM_PORT_WIDTH`  BRAM read data; registered, so it is valid 1 cycle after the address.
- sa_w_load  out  1  weight-line strobe to the array.
- sa_w_row  out  $clog2(ROWS)  destination row for sa_w_data.
- sa_w_data  out  `MEM_PORT_WIDTH`  weight line; equal to mem_dout.
- sa_in_valid  out  1  input-line strobe to the array.
- sa_in_data  out  `MEM_PORT_WIDTH`  input line; equal to mem_dout.
- sa_out_valid  in  1  array result row valid.
- sa_out_data  in  `MEM_PORT_WIDTH`  array result row.

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN, WRITE, DONE.
- IDLE
  - Outputs low, mem_addr = 0.
  - start=1 → LOAD_W; clears error, read counter, result count and drain counter.
- LOAD_W
  - Issues reads W_BASE..W_BASE+ROWS-1, one per cycle.
  - The cycle after each read: sa_w_load=1, sa_w_row = that read's index.
  - After the last read is issued → STREAM; its data returns during the first STREAM cycle.
- STREAM
  - Issues reads IN_BASE..IN_BASE+ROWS+COLS-2.
  - The cycle after each read: sa_in_valid=1.
  - After the last read is issued → DRAIN.
- Result capture, in any of LOAD_W/STREAM/DRAIN/WRITE
  - sa_out_valid=1 pushes sa_out_data into a COLS-deep buffer in arrival order.
  - A push when COLS entries are already held is dropped and sets error; the run continues.
- DRAIN
  - Emits the final sa_in_valid for the last STREAM read.
  - Counts cycles; → WRITE once the buffer holds COLS entries.
  - If the count reaches DRAIN_MAX first: error=1 → DONE, with no writes and no done pulse.
- WRITE
  - Pops one entry per cycle to OUT_BASE+k, k = 0..COLS-1, with mem_we=1 and mem_di = entry k.
  - After k = COLS-1 → DONE.
- DONE
  - done=1 for this one cycle, only when error=0 → IDLE.
- start outside IDLE is ignored. Reads never overlap writes; mem_we is high only in WRITE.
- Addresses: base + counter at ADDR_WIDTH, no wrap check; the bases are chosen so regions are disjoint.
- rst at any point
  - → IDLE next edge; counters and buffer cleared; all outputs 0.
  - The in-flight BRAM read result is discarded: no strobe follows reset.

## Timing
- Reset values: busy, done, error, mem_we, sa_w_load, sa_in_valid = 0; mem_addr, mem_di, sa_w_row = 0.
- Cycle 0 is the cycle start is sampled; the cycle-1 edge enters LOAD_W.
- Read issue is registered: mem_addr for a read is set at entry into a cycle, and data/strobe follow one cycle later.
- For ROWS = COLS = 4:
  - LOAD_W occupies cycles 1–4, with sa_w_load on cycles 2–5.
  - STREAM occupies cycles 5–11, with sa_in_valid on cycles 6–12.
  - Earliest WRITE is cycle 13 (results already buffered); writes on cycles 13–16, done on cycle 17, IDLE on cycle 18.
- Minimum run = 2*ROWS+2*COLS+1 cycles from start to done.
- sa_w_data and sa_in_data are combinational copies of mem_dout, qualified only by their strobes.

## Test plan
- Reset, then start with a preloaded BRAM (4x4 weights, 7 staggered inputs) and a model array returning the 4x4 product. Required:
  - sa_w_load on cycles 2–5 with rows 0–3.
  - 7 sa_in_valid pulses on cycles 6–12.
  - BRAM lines 11–14 end with the expected product rows.
  - done on cycle 17; error=0.
- Array returns results early, interleaved with STREAM → all 4 captured in order, written to 11–14, no extra mem_we.
- Array returns only 3 results → DRAIN times out after 64 cycles: error=1, no done, no mem_we, then IDLE.
- Array returns 5 results → error=1, first 4 written to 11–14, fifth dropped.
- rst asserted mid-STREAM → next cycle all outputs 0, IDLE; a following start runs cleanly with error cleared.
- start held high through a run, and pulsed during WRITE → exactly one run per IDLE entry; a second run begins the cycle after IDLE is re-entered.
